// File: rtl/fifo_simple_sync.sv
// Single-clock show-ahead FIFO with clock enable. The head word is always
// presented on read_data. Asserting read pops it, and asserting write pushes a word.
module fifo_simple_sync #(
   parameter int FIFO_DEPTH      = 2048,
   parameter int FIFO_DATA_WIDTH = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clk_enable,
   input  logic                       write,
   input  logic                       read,
   input  logic [FIFO_DATA_WIDTH-1:0] write_data,
   output logic [FIFO_DATA_WIDTH-1:0] read_data,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]              r_wr_ptr;
   logic [AW-1:0]              r_rd_ptr;
   logic [CW-1:0]              r_count;

   logic                       w_do_wr;
   logic                       w_do_rd;
   logic [AW-1:0]              w_wr_ptr_nxt;
   logic [AW-1:0]              w_rd_ptr_nxt;

   // Handshake: write is a request that is accepted on an enabled edge when
   // the FIFO is not full, and read is a request that is accepted when the FIFO is not empty.
   // Requests that are refused are dropped without any side effect.
   assign empty   = (r_count == '0);
   assign full    = (r_count == CW'(FIFO_DEPTH));
   assign w_do_wr = clk_enable & write & ~full;
   assign w_do_rd = clk_enable & read & ~empty;

   // The pointers wrap explicitly, so the depth does not need to be a power of two.
   assign w_wr_ptr_nxt = (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_nxt = (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_do_rd) r_rd_ptr <= w_rd_ptr_nxt;
         if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
         else if (w_do_rd && !w_do_wr) r_count <= r_count - 1'b1;
      end
   end

   // The storage is not reset. After a reset, its stale contents are unreachable because count is 0.
   always_ff @(posedge clk) begin
      if (w_do_wr && reset) r_mem[r_wr_ptr] <= write_data;
   end

   assign read_data = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_fifo_simple_sync.sv
// Randomised and directed bench for fifo_simple_sync. It drives a small instance (depth 4, width 8)
// and a default-parameter instance, and compares each instance against queue models.
module tb_fifo_simple_sync;

   localparam int SD = 4;
   localparam int SW = 8;
   localparam int BD = 2048;
   localparam int BW = 24;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          s_ce = 1'b0, s_write = 1'b0, s_read = 1'b0;
   logic [SW-1:0] s_wdata = '0;
   logic [SW-1:0] s_rdata;
   logic          s_empty, s_full;
   logic          b_ce = 1'b0, b_write = 1'b0, b_read = 1'b0;
   logic [BW-1:0] b_wdata = '0;
   logic [BW-1:0] b_rdata;
   logic          b_empty, b_full;

   logic [SW-1:0] s_q[$];
   logic [BW-1:0] b_q[$];
   int            total = 0;
   int            bad = 0;
   bit            checking = 1'b0;

   fifo_simple_sync #(.FIFO_DEPTH(SD), .FIFO_DATA_WIDTH(SW)) u_small (
      .clk(clk), .reset(reset), .clk_enable(s_ce), .write(s_write), .read(s_read),
      .write_data(s_wdata), .read_data(s_rdata), .empty(s_empty), .full(s_full)
   );

   fifo_simple_sync #(.FIFO_DEPTH(BD), .FIFO_DATA_WIDTH(BW)) u_big (
      .clk(clk), .reset(reset), .clk_enable(b_ce), .write(b_write), .read(b_read),
      .write_data(b_wdata), .read_data(b_rdata), .empty(b_empty), .full(b_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO is a bounded queue. The accept decisions are taken on the pre-edge occupancy.
   always @(posedge clk) begin
      if (reset && s_ce) begin
         automatic bit wr = s_write && (s_q.size() < SD);
         automatic bit rd = s_read && (s_q.size() > 0);
         if (rd) void'(s_q.pop_front());
         if (wr) s_q.push_back(s_wdata);
      end
      if (reset && b_ce) begin
         automatic bit wr = b_write && (b_q.size() < BD);
         automatic bit rd = b_read && (b_q.size() > 0);
         if (rd) void'(b_q.pop_front());
         if (wr) b_q.push_back(b_wdata);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("s_empty", 32'(s_empty), 32'(s_q.size() == 0));
         chk("s_full", 32'(s_full), 32'(s_q.size() == SD));
         if (s_q.size() > 0) chk("s_head", 32'(s_rdata), 32'(s_q[0]));
         chk("b_empty", 32'(b_empty), 32'(b_q.size() == 0));
         chk("b_full", 32'(b_full), 32'(b_q.size() == BD));
         if (b_q.size() > 0) chk("b_head", 32'(b_rdata), 32'(b_q[0]));
      end
   end

   // The inputs are applied just after a falling edge and are sampled at the next rising edge.
   task automatic cyc(input logic w, input logic r, input logic ce, input logic [SW-1:0] d);
      s_write = w; s_read = r; s_ce = ce; s_wdata = d;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      #2;
      reset = 1'b0;
      s_q.delete();
      b_q.delete();
      #1;
      chk("rst_empty_async", 32'(s_empty), 32'd1);
      chk("rst_full_async", 32'(s_full), 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      b_ce = 1'b1;
      checking = 1'b1;
      chk("init_empty", 32'(s_empty), 32'd1);
      chk("init_full", 32'(s_full), 32'd0);

      // Reset while words are stored, then push one word after the release.
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, SW'(8'h31 + i));
      chk("three_stored_head", 32'(s_rdata), 32'h31);
      apply_reset();
      cyc(1, 0, 1, 8'h11);
      chk("post_rst_head", 32'(s_rdata), 32'h11);
      cyc(0, 1, 1, 8'h00);
      chk("post_rst_drain", 32'(s_empty), 32'd1);

      // Fill the FIFO and overflow it. The fifth word must be dropped.
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 1, SW'(i + 1));
         if (i == 3) chk("full_after_4", 32'(s_full), 32'd1);
      end
      chk("full_hold", 32'(s_full), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("pop_order", 32'(s_rdata), 32'(i + 1));
         cyc(0, 1, 1, 8'h00);
      end
      chk("empty_after_pops", 32'(s_empty), 32'd1);

      // Read while the FIFO is empty, then push a word.
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'h00);
      chk("underflow_empty", 32'(s_empty), 32'd1);
      cyc(1, 0, 1, 8'hAA);
      chk("after_underflow_head", 32'(s_rdata), 32'hAA);
      chk("after_underflow_empty", 32'(s_empty), 32'd0);
      cyc(0, 1, 1, 8'h00);

      // Simultaneous write and read with two words held. The pointers wrap several times.
      cyc(1, 0, 1, 8'h20);
      cyc(1, 0, 1, 8'h21);
      for (int k = 1; k <= 10; k++) begin
         cyc(1, 1, 1, SW'(8'h21 + k));
         chk("rw_head", 32'(s_rdata), 32'(8'h20 + k));
         chk("rw_not_full", 32'(s_full), 32'd0);
      end

      // With the clock enable low, write and read are both held high. Nothing may change.
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 0, 8'hEE);
         chk("ce_hold_head", 32'(s_rdata), 32'h2A);
      end
      cyc(0, 1, 1, 8'h00);
      chk("ce_resume_head", 32'(s_rdata), 32'h2B);
      cyc(0, 1, 1, 8'h00);
      chk("ce_resume_empty", 32'(s_empty), 32'd1);

      // Random stimulus. An occasional asynchronous reset is applied.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) apply_reset();
         cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
             1'($urandom_range(0, 9) != 0), SW'($urandom));
      end
      cyc(0, 0, 1, 8'h00);

      // Run the default-parameter instance through a complete fill and drain.
      b_write = 1'b1;
      for (int i = 0; i < BD; i++) begin
         b_wdata = BW'(i);
         @(negedge clk);
      end
      b_write = 1'b0;
      chk("big_full", 32'(b_full), 32'd1);
      chk("big_head0", 32'(b_rdata), 32'h0);
      b_read = 1'b1;
      for (int i = 0; i < BD; i++) begin
         if (b_rdata !== BW'(i)) chk("big_order", 32'(b_rdata), 32'(i));
         else total++;
         @(negedge clk);
      end
      b_read = 1'b0;
      chk("big_empty", 32'(b_empty), 32'd1);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
